// File: rtl/ls_pkg.sv
// Shared types and lane helpers for the queued load/store unit.
// Helpers work on 64-bit words; callers zero-extend/truncate to DATA_W.
package ls_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'd0,
    SZ_HALF   = 2'd1,
    SZ_WORD   = 2'd2,
    SZ_DOUBLE = 2'd3
  } Ls_size;

  typedef enum logic [1:0] {
    CAUSE_NONE       = 2'd0,
    CAUSE_MISALIGNED = 2'd1,
    CAUSE_ILLEGAL    = 2'd2
  } Ls_cause;

  localparam int LS_MAX_DATA_W = 64;
  localparam int LS_OFF_W      = 3;

  // Control part of a queue entry; tag and pc travel as a separate payload
  // because their widths are parameters of the unit.
  typedef struct packed {
    Ls_size              size;
    logic                sign;
    logic [LS_OFF_W-1:0] off;
    logic                store;
    logic                live;
  } Ls_entry;

  function automatic logic [7:0] be_gen(input Ls_size size, input logic [LS_OFF_W-1:0] off);
    logic [7:0] be;
    case (size)
      SZ_BYTE: be = 8'h01 << off;
      SZ_HALF: be = 8'h03 << off;
      SZ_WORD: be = 8'h0F << off;
      default: be = 8'hFF;
    endcase
    return be;
  endfunction

  function automatic logic [LS_MAX_DATA_W-1:0] store_replicate(input Ls_size size,
                                                                input logic [LS_MAX_DATA_W-1:0] data);
    logic [LS_MAX_DATA_W-1:0] r;
    case (size)
      SZ_BYTE: r = {8{data[7:0]}};
      SZ_HALF: r = {4{data[15:0]}};
      SZ_WORD: r = {2{data[31:0]}};
      default: r = data;
    endcase
    return r;
  endfunction

  function automatic logic [LS_MAX_DATA_W-1:0] load_extract(input Ls_size size, input logic sign,
                                                             input logic [LS_OFF_W-1:0] off,
                                                             input logic [LS_MAX_DATA_W-1:0] rdata);
    logic [LS_MAX_DATA_W-1:0] sh;
    logic [LS_MAX_DATA_W-1:0] r;
    sh = rdata >> {off, 3'b000};
    case (size)
      SZ_BYTE: r = sign ? {{56{sh[7]}}, sh[7:0]}   : {56'd0, sh[7:0]};
      SZ_HALF: r = sign ? {{48{sh[15]}}, sh[15:0]} : {48'd0, sh[15:0]};
      SZ_WORD: r = sign ? {{32{sh[31]}}, sh[31:0]} : {32'd0, sh[31:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ls_tag_queue.sv
// In-order FIFO of outstanding memory operations with a one-cycle clear of
// every entry's live bit, so flushed operations drain without producing results.
module ls_tag_queue
  import ls_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = 38
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  Ls_entry       push_entry,
  input  logic [PW-1:0] push_payload,
  input  logic          pop,
  input  logic          clear_live,
  output Ls_entry       head_entry,
  output logic [PW-1:0] head_payload,
  output logic          full,
  output logic          empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  Ls_entry          entry_mem   [DEPTH];
  logic [PW-1:0]    payload_mem [DEPTH];
  logic [DEPTH-1:0] live_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      entry_mem[wr_ptr_reg]   <= push_entry;
      payload_mem[wr_ptr_reg] <= push_payload;
    end
  end

  // A push in the same cycle as a clear is newer than the flush and keeps its live bit.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_live
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        live_reg[gi] <= 1'b0;
      end else if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
        live_reg[gi] <= push_entry.live;
      end else if (clear_live) begin
        live_reg[gi] <= 1'b0;
      end
    end
  end

  always_comb begin
    head_entry      = entry_mem[rd_ptr_reg];
    head_entry.live = live_reg[rd_ptr_reg];
    head_payload    = payload_mem[rd_ptr_reg];
  end

endmodule

// File: rtl/ls_unit_queued.sv
// Decoupled load/store unit: address check, memory request encoding, in-order
// tracking of up to DEPTH outstanding requests and load result extraction.
module ls_unit_queued
  import ls_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TAG_W   = 6,
  parameter int DEPTH   = 4,
  parameter int OUT_REG = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic                issue_store,
  input  logic [1:0]          issue_size,
  input  logic                issue_signed,
  input  logic [ADDR_W-1:0]   issue_a,
  input  logic [ADDR_W-1:0]   issue_b,
  input  logic [DATA_W-1:0]   issue_c,
  input  logic [TAG_W-1:0]    issue_tag,
  input  logic [ADDR_W-1:0]   issue_pc,
  input  logic                flush,
  output logic                dmem_req_valid,
  input  logic                dmem_req_ready,
  output logic                dmem_we,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [DATA_W/8-1:0] dmem_be,
  output logic [DATA_W-1:0]   dmem_wdata,
  input  logic                dmem_resp_valid,
  input  logic [DATA_W-1:0]   dmem_rdata,
  output logic                res_valid,
  output logic [TAG_W-1:0]    res_tag,
  output logic [DATA_W-1:0]   res_data,
  output logic [ADDR_W-1:0]   res_pc,
  output logic                exc_valid,
  output logic [1:0]          exc_cause,
  output logic [ADDR_W-1:0]   exc_pc
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int PW    = TAG_W + ADDR_W;

  logic [ADDR_W-1:0] addr;
  logic [OFF_W-1:0]  off;
  Ls_size            size;
  Ls_cause           cause_now;
  logic              illegal;
  logic              misaligned;
  logic              faulting;
  logic              active_reg;
  logic              full;
  logic              empty;
  logic              accept;
  logic              push;
  logic              pop;
  logic              produce;
  logic              exc_now;
  Ls_entry           push_entry;
  Ls_entry           head_entry;
  logic [PW-1:0]     head_payload;

  logic              res_valid_next;
  logic [TAG_W-1:0]  res_tag_next;
  logic [DATA_W-1:0] res_data_next;
  logic [ADDR_W-1:0] res_pc_next;
  logic              exc_valid_next;
  logic [1:0]        exc_cause_next;
  logic [ADDR_W-1:0] exc_pc_next;

  // Holds the issue side closed while reset is asserted and for the first edge after it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) active_reg <= 1'b0;
    else       active_reg <= 1'b1;
  end

  assign addr    = issue_a + issue_b;
  assign off     = addr[OFF_W-1:0];
  assign size    = Ls_size'(issue_size);
  assign illegal = (size == SZ_DOUBLE) && (DATA_W == 32);

  always_comb begin
    misaligned = 1'b0;
    case (size)
      SZ_HALF:   misaligned = addr[0];
      SZ_WORD:   misaligned = |addr[1:0];
      SZ_DOUBLE: misaligned = |addr[2:0];
      default:   misaligned = 1'b0;
    endcase
  end

  assign faulting  = illegal || misaligned;
  assign cause_now = illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGNED;

  // Faulting operations never reach memory, so they do not wait for dmem_req_ready.
  assign issue_ready    = active_reg && !full && !flush && (faulting || dmem_req_ready);
  assign dmem_req_valid = active_reg && issue_valid && !full && !flush && !faulting;
  assign accept         = issue_valid && issue_ready;
  assign push           = accept && !faulting;
  assign exc_now        = accept && faulting;

  assign dmem_we    = dmem_req_valid && issue_store;
  assign dmem_addr  = dmem_req_valid ? {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign dmem_be    = dmem_req_valid ? NB'(be_gen(size, LS_OFF_W'(off))) : '0;
  assign dmem_wdata = dmem_req_valid ?
                      DATA_W'(store_replicate(size, LS_MAX_DATA_W'(issue_c))) : '0;

  assign push_entry = '{size: size, sign: issue_signed, off: LS_OFF_W'(off),
                        store: issue_store, live: 1'b1};

  ls_tag_queue #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_queue (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .push_entry   (push_entry),
    .push_payload ({issue_tag, issue_pc}),
    .pop          (pop),
    .clear_live   (flush),
    .head_entry   (head_entry),
    .head_payload (head_payload),
    .full         (full),
    .empty        (empty)
  );

  // A response landing in the flush cycle still pops but is killed here.
  assign pop     = dmem_resp_valid && !empty;
  assign produce = pop && head_entry.live && !head_entry.store && !flush;

  assign res_valid_next = produce;
  assign res_tag_next   = produce ? head_payload[PW-1:ADDR_W] : '0;
  assign res_pc_next    = produce ? head_payload[ADDR_W-1:0] : '0;
  assign res_data_next  = produce ?
                          DATA_W'(load_extract(head_entry.size, head_entry.sign, head_entry.off,
                                               LS_MAX_DATA_W'(dmem_rdata))) : '0;
  assign exc_valid_next = exc_now;
  assign exc_cause_next = exc_now ? cause_now : CAUSE_NONE;
  assign exc_pc_next    = exc_now ? issue_pc : '0;

  if (OUT_REG != 0) begin : g_out_reg
    logic              res_valid_reg;
    logic [TAG_W-1:0]  res_tag_reg;
    logic [DATA_W-1:0] res_data_reg;
    logic [ADDR_W-1:0] res_pc_reg;
    logic              exc_valid_reg;
    logic [1:0]        exc_cause_reg;
    logic [ADDR_W-1:0] exc_pc_reg;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        res_valid_reg <= 1'b0;
        res_tag_reg   <= '0;
        res_data_reg  <= '0;
        res_pc_reg    <= '0;
        exc_valid_reg <= 1'b0;
        exc_cause_reg <= '0;
        exc_pc_reg    <= '0;
      end else begin
        res_valid_reg <= res_valid_next;
        res_tag_reg   <= res_tag_next;
        res_data_reg  <= res_data_next;
        res_pc_reg    <= res_pc_next;
        exc_valid_reg <= exc_valid_next;
        exc_cause_reg <= exc_cause_next;
        exc_pc_reg    <= exc_pc_next;
      end
    end

    assign res_valid = res_valid_reg;
    assign res_tag   = res_tag_reg;
    assign res_data  = res_data_reg;
    assign res_pc    = res_pc_reg;
    assign exc_valid = exc_valid_reg;
    assign exc_cause = exc_cause_reg;
    assign exc_pc    = exc_pc_reg;
  end else begin : g_out_comb
    assign res_valid = res_valid_next;
    assign res_tag   = res_tag_next;
    assign res_data  = res_data_next;
    assign res_pc    = res_pc_next;
    assign exc_valid = exc_valid_next;
    assign exc_cause = exc_cause_next;
    assign exc_pc    = exc_pc_next;
  end

endmodule

// File: tb/tb_ls_unit_queued.sv
// Directed bench for ls_unit_queued with a behavioural data RAM of selectable latency.
module tb_ls_unit_queued;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_ready, issue_store, issue_signed;
  logic [1:0]  issue_size;
  logic [31:0] issue_a, issue_b, issue_c, issue_pc;
  logic [5:0]  issue_tag;
  logic        flush;
  logic        dmem_req_valid, dmem_req_ready, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_resp_valid;
  logic        res_valid, exc_valid;
  logic [5:0]  res_tag;
  logic [31:0] res_data, res_pc, exc_pc;
  logic [1:0]  exc_cause;

  int tests_run = 0;
  int tests_failed = 0;
  int lat = 1;
  int cyc = 0;

  logic [31:0] mem [0:1023];
  typedef struct { int due; logic [31:0] data; } resp_t;
  resp_t pend[$];

  logic [5:0]  rq_tag[$];
  logic [31:0] rq_data[$];
  logic [31:0] rq_pc[$];
  logic [1:0]  eq_cause[$];
  logic [31:0] eq_pc[$];

  logic        cap_reqv, cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;

  ls_unit_queued #(
    .DATA_W(32), .ADDR_W(32), .TAG_W(6), .DEPTH(4), .OUT_REG(1)
  ) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_store(issue_store),
    .issue_size(issue_size), .issue_signed(issue_signed), .issue_a(issue_a), .issue_b(issue_b),
    .issue_c(issue_c), .issue_tag(issue_tag), .issue_pc(issue_pc), .flush(flush),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_resp_valid(dmem_resp_valid), .dmem_rdata(dmem_rdata),
    .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data), .res_pc(res_pc),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc)
  );

  initial forever #5 clk = ~clk;

  // Memory: requests sampled late in the low phase, responses driven just after the edge.
  initial begin
    dmem_resp_valid = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(negedge clk);
      #3;
      if (!reset && dmem_req_valid && dmem_req_ready) begin
        resp_t r;
        r.due = cyc + lat;
        r.data = '0;
        if (dmem_we) begin
          for (int b = 0; b < 4; b++)
            if (dmem_be[b]) mem[dmem_addr[11:2]][b*8 +: 8] = dmem_wdata[b*8 +: 8];
        end else begin
          r.data = mem[dmem_addr[11:2]];
        end
        pend.push_back(r);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        dmem_resp_valid = 1'b1;
        dmem_rdata = pend[0].data;
        void'(pend.pop_front());
      end else begin
        dmem_resp_valid = 1'b0;
        dmem_rdata = '0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    #2;
    if (res_valid) begin
      rq_tag.push_back(res_tag);
      rq_data.push_back(res_data);
      rq_pc.push_back(res_pc);
    end
    if (exc_valid) begin
      eq_cause.push_back(exc_cause);
      eq_pc.push_back(exc_pc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_obs();
    rq_tag.delete(); rq_data.delete(); rq_pc.delete();
    eq_cause.delete(); eq_pc.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one operation starting at a negedge; returns at the negedge after acceptance.
  task automatic issue_op(input logic st, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          input logic [5:0] tg, input logic [31:0] pc, output int refused);
    issue_valid = 1'b1; issue_store = st; issue_size = sz; issue_signed = sg;
    issue_a = a; issue_b = b; issue_c = c; issue_tag = tg; issue_pc = pc;
    refused = 0;
    forever begin
      #1;
      if (issue_ready || refused >= 30) break;
      @(negedge clk);
      refused++;
    end
    cap_reqv = dmem_req_valid; cap_we = dmem_we; cap_addr = dmem_addr;
    cap_be = dmem_be; cap_wdata = dmem_wdata;
    @(negedge clk);
    issue_valid = 1'b0;
  endtask

  task automatic wait_res(input int n, input int budget, output int cycles);
    cycles = 0;
    forever begin
      #3;
      if (rq_tag.size() >= n || cycles >= budget) break;
      @(negedge clk);
      cycles++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; dmem_req_ready = 1'b1;
    issue_valid = 1'b1; issue_store = 1'b0; issue_size = 2'd2; issue_signed = 1'b0;
    issue_a = 32'h100; issue_b = 32'h4; issue_c = '0; issue_tag = 6'd1; issue_pc = 32'h44;
    idle(2);
    #1;
    tests_run++; if (issue_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_issue_ready got %b exp 0", issue_ready); end
    tests_run++; if (dmem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_req_valid got %b exp 0", dmem_req_valid); end
    tests_run++; if (dmem_be !== 4'h0) begin tests_failed++; $display("FAIL rst_be got %h exp 0", dmem_be); end
    tests_run++; if ({res_valid, exc_valid} !== 2'b00) begin tests_failed++; $display("FAIL rst_valids got %b exp 00", {res_valid, exc_valid}); end
    tests_run++; if ({res_tag, res_data, res_pc} !== 70'd0) begin tests_failed++; $display("FAIL rst_res_fields got %h exp 0", {res_tag, res_data, res_pc}); end
    tests_run++; if ({exc_cause, exc_pc} !== 34'd0) begin tests_failed++; $display("FAIL rst_exc_fields got %h exp 0", {exc_cause, exc_pc}); end
    @(negedge clk);
    reset = 1'b0; issue_valid = 1'b0;
    idle(2);
    $display("[TB] reset checks done");
  endtask

  task automatic test_load_word();
    int refused, cycles;
    clear_obs();
    mem[32'h104 >> 2] = 32'hDEADBEEF;
    issue_op(1'b0, 2'd2, 1'b0, 32'h100, 32'h4, 32'h0, 6'd5, 32'h1000, refused);
    tests_run++; if (refused !== 0) begin tests_failed++; $display("FAIL lw_refused got %0d exp 0", refused); end
    tests_run++; if ({cap_reqv, cap_we} !== 2'b10) begin tests_failed++; $display("FAIL lw_req_we got %b exp 10", {cap_reqv, cap_we}); end
    tests_run++; if (cap_addr !== 32'h104) begin tests_failed++; $display("FAIL lw_addr got %h exp 00000104", cap_addr); end
    tests_run++; if (cap_be !== 4'hF) begin tests_failed++; $display("FAIL lw_be got %h exp f", cap_be); end
    wait_res(1, 10, cycles);
    tests_run++; if (cycles !== 1) begin tests_failed++; $display("FAIL lw_latency got %0d exp 1", cycles); end
    tests_run++; if (rq_tag.size() !== 1 || rq_tag[0] !== 6'd5) begin tests_failed++; $display("FAIL lw_tag got n=%0d exp tag 5", rq_tag.size()); end
    tests_run++; if (rq_data.size() !== 1 || rq_data[0] !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL lw_data got n=%0d exp deadbeef", rq_data.size()); end
    tests_run++; if (rq_pc.size() !== 1 || rq_pc[0] !== 32'h1000) begin tests_failed++; $display("FAIL lw_pc got n=%0d exp 00001000", rq_pc.size()); end
    $display("[TB] load word addr=%h be=%h latency=%0d", cap_addr, cap_be, cycles);
  endtask

  task automatic test_subword_load();
    int refused, cycles;
    clear_obs();
    mem[32'h104 >> 2] = 32'h80FFFFFF;
    issue_op(1'b0, 2'd0, 1'b1, 32'h100, 32'h7, 32'h0, 6'd6, 32'h1004, refused);
    tests_run++; if (cap_be !== 4'h8) begin tests_failed++; $display("FAIL lb_be got %h exp 8", cap_be); end
    tests_run++; if (cap_addr !== 32'h104) begin tests_failed++; $display("FAIL lb_addr got %h exp 00000104", cap_addr); end
    issue_op(1'b0, 2'd0, 1'b0, 32'h100, 32'h7, 32'h0, 6'd7, 32'h1008, refused);
    issue_op(1'b0, 2'd1, 1'b1, 32'h100, 32'h6, 32'h0, 6'd8, 32'h100C, refused);
    tests_run++; if (cap_be !== 4'hC) begin tests_failed++; $display("FAIL lh_be got %h exp c", cap_be); end
    wait_res(3, 10, cycles);
    tests_run++; if (rq_data.size() !== 3) begin tests_failed++; $display("FAIL sub_count got %0d exp 3", rq_data.size()); end
    else begin
      tests_run++; if (rq_data[0] !== 32'hFFFFFF80) begin tests_failed++; $display("FAIL lb_signed got %h exp ffffff80", rq_data[0]); end
      tests_run++; if (rq_data[1] !== 32'h00000080) begin tests_failed++; $display("FAIL lb_unsigned got %h exp 00000080", rq_data[1]); end
      tests_run++; if (rq_data[2] !== 32'hFFFF80FF) begin tests_failed++; $display("FAIL lh_signed got %h exp ffff80ff", rq_data[2]); end
      tests_run++; if ({rq_tag[0], rq_tag[1], rq_tag[2]} !== {6'd6, 6'd7, 6'd8}) begin tests_failed++; $display("FAIL sub_tags got %0d %0d %0d exp 6 7 8", rq_tag[0], rq_tag[1], rq_tag[2]); end
    end
    $display("[TB] sub-word loads results=%0d", rq_data.size());
  endtask

  task automatic test_store_half();
    int refused, cycles;
    clear_obs();
    mem[32'h200 >> 2] = 32'h55667788;
    issue_op(1'b1, 2'd1, 1'b0, 32'h200, 32'h2, 32'hABCD1234, 6'd9, 32'h1010, refused);
    tests_run++; if ({cap_reqv, cap_we} !== 2'b11) begin tests_failed++; $display("FAIL sh_req_we got %b exp 11", {cap_reqv, cap_we}); end
    tests_run++; if (cap_be !== 4'hC) begin tests_failed++; $display("FAIL sh_be got %h exp c", cap_be); end
    tests_run++; if (cap_wdata !== 32'h12341234) begin tests_failed++; $display("FAIL sh_wdata got %h exp 12341234", cap_wdata); end
    tests_run++; if (cap_addr !== 32'h200) begin tests_failed++; $display("FAIL sh_addr got %h exp 00000200", cap_addr); end
    idle(4);
    tests_run++; if (rq_tag.size() !== 0) begin tests_failed++; $display("FAIL sh_no_result got %0d results exp 0", rq_tag.size()); end
    issue_op(1'b0, 2'd2, 1'b0, 32'h1F0, 32'h10, 32'h0, 6'd10, 32'h1014, refused);
    wait_res(1, 10, cycles);
    tests_run++; if (rq_data.size() !== 1 || rq_data[0] !== 32'h12347788) begin tests_failed++; $display("FAIL sh_readback got n=%0d exp 12347788", rq_data.size()); end
    $display("[TB] store half be=%h wdata=%h", cap_be, cap_wdata);
  endtask

  task automatic test_faults();
    int refused;
    clear_obs();
    issue_op(1'b0, 2'd2, 1'b0, 32'h100, 32'h2, 32'h0, 6'd11, 32'h2000, refused);
    tests_run++; if ({refused == 0, cap_reqv} !== 2'b10) begin tests_failed++; $display("FAIL mis_no_req got refused=%0d req=%b exp 0 0", refused, cap_reqv); end
    #3;
    tests_run++; if ({exc_valid, exc_cause, exc_pc} !== {1'b1, 2'd1, 32'h2000}) begin tests_failed++; $display("FAIL mis_exc got v=%b c=%0d pc=%h exp 1 1 00002000", exc_valid, exc_cause, exc_pc); end
    @(negedge clk);
    idle(3);
    tests_run++; if (eq_cause.size() !== 1) begin tests_failed++; $display("FAIL mis_pulse got %0d cycles exp 1", eq_cause.size()); end
    issue_op(1'b0, 2'd3, 1'b0, 32'h100, 32'h1, 32'h0, 6'd12, 32'h2004, refused);
    idle(3);
    tests_run++; if (eq_cause.size() !== 2 || eq_cause[1] !== 2'd2 || eq_pc[1] !== 32'h2004) begin tests_failed++; $display("FAIL ill_exc got n=%0d exp cause 2 pc 00002004", eq_cause.size()); end
    issue_op(1'b0, 2'd1, 1'b0, 32'h100, 32'h1, 32'h0, 6'd13, 32'h2008, refused);
    idle(3);
    tests_run++; if (eq_cause.size() !== 3 || eq_cause[2] !== 2'd1) begin tests_failed++; $display("FAIL mish_exc got n=%0d exp cause 1", eq_cause.size()); end
    tests_run++; if (rq_tag.size() !== 0) begin tests_failed++; $display("FAIL fault_no_result got %0d exp 0", rq_tag.size()); end
    $display("[TB] faults exceptions=%0d", eq_cause.size());
  endtask

  task automatic test_back_to_back();
    int refused, total_refused, cycles;
    logic [31:0] vals [5];
    vals[0] = 32'hCAFE0000; vals[1] = 32'hCAFE1111; vals[2] = 32'hCAFE2222;
    vals[3] = 32'hCAFE3333; vals[4] = 32'hCAFE4444;
    clear_obs();
    lat = 4;
    for (int i = 0; i < 5; i++) mem[(32'h240 >> 2) + i] = vals[i];
    total_refused = 0;
    for (int i = 0; i < 4; i++) begin
      issue_op(1'b0, 2'd2, 1'b0, 32'h240, 32'(i * 4), 32'h0, 6'(20 + i), 32'h3000 + 32'(i * 4), refused);
      total_refused += refused;
    end
    tests_run++; if (total_refused !== 0) begin tests_failed++; $display("FAIL b2b_first4 got %0d stalls exp 0", total_refused); end
    issue_op(1'b0, 2'd2, 1'b0, 32'h240, 32'd16, 32'h0, 6'd24, 32'h3010, refused);
    tests_run++; if (refused !== 1) begin tests_failed++; $display("FAIL b2b_fifth_stall got %0d exp 1", refused); end
    wait_res(5, 40, cycles);
    tests_run++; if (rq_tag.size() !== 5) begin tests_failed++; $display("FAIL b2b_count got %0d exp 5", rq_tag.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        tests_run++;
        if (rq_tag[i] !== 6'(20 + i) || rq_data[i] !== vals[i]) begin
          tests_failed++;
          $display("FAIL b2b_result%0d got tag %0d data %h exp tag %0d data %h", i, rq_tag[i], rq_data[i], 20 + i, vals[i]);
        end
      end
    end
    $display("[TB] back-to-back results=%0d fifth stall=%0d", rq_tag.size(), refused);
  endtask

  task automatic test_flush();
    int refused, cycles;
    clear_obs();
    lat = 4;
    mem[32'h300 >> 2] = 32'h0BADF00D;
    for (int i = 0; i < 3; i++)
      issue_op(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h0, 6'(30 + i), 32'h4000, refused);
    flush = 1'b1;
    issue_valid = 1'b1; issue_size = 2'd2; issue_a = 32'h300; issue_b = 32'h0; issue_tag = 6'd40;
    #1;
    tests_run++; if ({issue_ready, dmem_req_valid} !== 2'b00) begin tests_failed++; $display("FAIL flush_refuse got %b exp 00", {issue_ready, dmem_req_valid}); end
    @(negedge clk);
    flush = 1'b0; issue_valid = 1'b0;
    idle(8);
    tests_run++; if (rq_tag.size() !== 0) begin tests_failed++; $display("FAIL flush_killed got %0d results exp 0", rq_tag.size()); end
    issue_op(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h0, 6'd33, 32'h4010, refused);
    wait_res(1, 20, cycles);
    tests_run++; if (cycles !== 4) begin tests_failed++; $display("FAIL flush_next_latency got %0d exp 4", cycles); end
    tests_run++; if (rq_tag.size() !== 1 || rq_tag[0] !== 6'd33 || rq_data[0] !== 32'h0BADF00D) begin tests_failed++; $display("FAIL flush_next_result got n=%0d exp tag 33 data 0badf00d", rq_tag.size()); end
    $display("[TB] flush then load results=%0d", rq_tag.size());
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_subword_load();
    test_store_half();
    test_faults();
    test_back_to_back();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
